histogram_axi_multi: RTL

//  Per-frame histogram engine for 1..4 pixel channels in one clock domain. A CPU trigger

---
 rtl/histogram_axi_multi.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/histogram_axi_multi.sv
// histogram_axi_multi: per-frame histogram engine for 1..4 pixel channels.
// A CPU trigger arms it to optionally clear the bins, wait for a frame start,
// count one frame and then raise done. Results and status are read back over
// an AXI4-Lite read-only slave.
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   pix_i, dv_i, vs_i        pixel stream (channel c at [c*PIX_BITS +: PIX_BITS]), valid, vsync
//   cpu_trigger, cpu_accum   arm pulse; accum=1 keeps the previous counts
//   cpu_signal_done          high while the result is complete (DONE)
//   s_axi_ar*, s_axi_r*      AXI4-Lite read address / read data channels
module histogram_axi_multi #(
    parameter int unsigned PIX_BITS = 8,
    parameter int unsigned BIN_BITS = 8,
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned CNT_BITS = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*PIX_BITS-1:0] pix_i,
    input  logic                         dv_i,
    input  logic                         vs_i,
    input  logic                         cpu_trigger,
    input  logic                         cpu_accum,
    output logic                         cpu_signal_done,
    input  logic [31:0]                  s_axi_araddr,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [31:0]                  s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready
);

    localparam int unsigned CH_BITS = 2;
    localparam int unsigned NBINS   = 1 << BIN_BITS;
    localparam int unsigned REG_BIT = BIN_BITS + CH_BITS + 2;
    localparam int unsigned WORD_W  = BIN_BITS + CH_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_VS,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_e;

    // Control state
    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic                accum_q, accum_d;
    logic                drain_q, drain_d;
    logic                done_q;
    logic                vs_q;
    logic [BIN_BITS-1:0] clr_q, clr_d;
    logic [CNT_BITS-1:0] pix_cnt_q, pix_cnt_d, pix_base_c;
    logic                vs_rise_c, count_en_c;

    // Counting pipeline and bin storage
    logic                v1_q, v2_q;
    logic [BIN_BITS-1:0] idx1_q [CHANNELS];
    logic [BIN_BITS-1:0] idx2_q [CHANNELS];
    logic [CNT_BITS-1:0] rd2_q  [CHANNELS];
    logic [CNT_BITS-1:0] inc_c  [CHANNELS];
    logic [CNT_BITS-1:0] rdb_q  [CHANNELS];
    logic [CNT_BITS-1:0] mem_q  [CHANNELS][NBINS];

    // AXI read side
    logic                arready_q, pend_q, rvalid_q;
    logic [REG_BIT:2]    addr_q;
    logic [31:0]         rdata_q, rdata_c;
    logic [1:0]          rresp_q, rresp_c;
    logic                ar_hs_c, busy_c, rd_allow_c;
    logic [CH_BITS-1:0]  ch_c;
    logic [WORD_W-1:0]   word_c;
    logic                unused_c;

    assign vs_rise_c  = vs_i & ~vs_q;
    // Window is [rise_k, rise_k+1): opening-edge pixel counts, closing-edge pixel does not.
    assign count_en_c = dv_i & (((state_q == S_WAIT_VS) & vs_rise_c) |
                                ((state_q == S_ACCUM) & ~vs_rise_c));

    // Next-state and control
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        accum_d = accum_q;
        drain_d = drain_q;
        clr_d   = clr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (cpu_trigger) begin
                    valid_d = 1'b0;
                    accum_d = cpu_accum & valid_q;
                    clr_d   = '0;
                    state_d = (cpu_accum && valid_q) ? S_WAIT_VS : S_CLEAR;
                end
            end
            S_CLEAR: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == {BIN_BITS{1'b1}}) state_d = S_WAIT_VS;
            end
            S_WAIT_VS: begin
                if (vs_rise_c) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (vs_rise_c) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                // Two cycles let the last pixel leave the write stage.
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pix_base_c = pix_cnt_q;
        if ((state_q == S_WAIT_VS) && vs_rise_c && !accum_q) pix_base_c = '0;
        pix_cnt_d = pix_base_c;
        if (count_en_c && (pix_base_c != {CNT_BITS{1'b1}})) pix_cnt_d = pix_base_c + 1'b1;
    end

    // Control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            accum_q   <= 1'b0;
            drain_q   <= 1'b0;
            done_q    <= 1'b0;
            vs_q      <= 1'b0;
            clr_q     <= '0;
            pix_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            accum_q   <= accum_d;
            drain_q   <= drain_d;
            done_q    <= (state_d == S_DONE);
            vs_q      <= vs_i;
            clr_q     <= clr_d;
            pix_cnt_q <= pix_cnt_d;
        end
    end

    // Saturating increment of the value read for the write stage
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            inc_c[c] = (rd2_q[c] == {CNT_BITS{1'b1}}) ? rd2_q[c] : rd2_q[c] + 1'b1;
        end
    end

    // Pipeline stage 1: bin index capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                idx1_q[c] <= '0;
                idx2_q[c] <= '0;
            end
        end else begin
            v1_q <= count_en_c;
            v2_q <= v1_q;
            for (int c = 0; c < CHANNELS; c++) begin
                idx1_q[c] <= pix_i[c*PIX_BITS + PIX_BITS - 1 -: BIN_BITS];
                idx2_q[c] <= idx1_q[c];
            end
        end
    end

    // Bin RAM: port A does clear / read-modify-write, port B serves AXI reads.
    // A read hitting the bin being written this cycle takes the write value instead.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (state_q == S_CLEAR) begin
                mem_q[c][clr_q] <= '0;
            end else if (v2_q) begin
                mem_q[c][idx2_q[c]] <= inc_c[c];
            end
            rd2_q[c] <= (v2_q && (idx2_q[c] == idx1_q[c])) ? inc_c[c] : mem_q[c][idx1_q[c]];
            if (ar_hs_c) rdb_q[c] <= mem_q[c][s_axi_araddr[BIN_BITS+1:2]];
        end
    end

    assign ar_hs_c    = s_axi_arvalid & arready_q;
    assign busy_c     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign rd_allow_c = (state_q == S_DONE) || ((state_q == S_IDLE) && valid_q);
    assign ch_c       = addr_q[BIN_BITS+3:BIN_BITS+2];
    assign word_c     = addr_q[BIN_BITS+3:2];
    assign unused_c   = ^{s_axi_araddr[31:REG_BIT+1], s_axi_araddr[1:0]};

    // Read response decode
    always_comb begin
        rdata_c = '0;
        rresp_c = 2'b00;
        if (addr_q[REG_BIT]) begin
            if (word_c == WORD_W'(0))      rdata_c = {29'b0, valid_q, done_q, busy_c};
            else if (word_c == WORD_W'(1)) rdata_c = 32'(pix_cnt_q);
            else if (word_c == WORD_W'(2)) rdata_c = {8'h00, 8'(CNT_BITS), 8'(CHANNELS), 8'(BIN_BITS)};
        end else if (!rd_allow_c) begin
            rresp_c = 2'b10;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (ch_c == CH_BITS'(c)) rdata_c = 32'(rdb_q[c]);
            end
        end
    end

    // AXI read handshake: accept, one cycle for the RAM read, then hold until taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arready_q <= 1'b1;
            pend_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            addr_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            if (ar_hs_c) begin
                arready_q <= 1'b0;
                pend_q    <= 1'b1;
                addr_q    <= s_axi_araddr[REG_BIT:2];
            end
            if (pend_q) begin
                pend_q   <= 1'b0;
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_c;
                rresp_q  <= rresp_c;
            end else if (rvalid_q && s_axi_rready) begin
                rvalid_q  <= 1'b0;
                arready_q <= 1'b1;
            end
        end
    end

    assign cpu_signal_done = done_q;
    assign s_axi_arready   = arready_q;
    assign s_axi_rvalid    = rvalid_q;
    assign s_axi_rdata     = rdata_q;
    assign s_axi_rresp     = rresp_q;

endmodule
